// File: rtl/sprite_pos_animator.sv
// Sprite position animator: maps slot codes to a fixed x/y table and glides the
// sprite horizontally toward the requested slot at up to SPEED pixels per frame.
module sprite_pos_animator #(
  parameter int NUM_SLOTS = 6,
  parameter int POS_W     = 8,
  parameter int COORD_W   = 10,
  parameter int X0        = 6,
  parameter int X1        = 42,
  parameter int X_STEP    = 40,
  parameter int Y_ROW     = 51,
  parameter int SPEED     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [POS_W-1:0]   pos,
  input  logic               pos_valid,
  input  logic               visible,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               visible_cond,
  output logic               busy,
  output logic               arrived
);

  typedef enum logic [1:0] {HIDDEN, IDLE, MOVING} state_t;

  localparam logic [COORD_W:0]   SPD  = (COORD_W+1)'(SPEED);
  localparam logic [COORD_W-1:0] YROW = COORD_W'(Y_ROW);

  function automatic int slot_x_of(input int k);
    if (k == 1) return X0;
    return X1 + (k - 2) * X_STEP;
  endfunction

  logic [COORD_W-1:0] slot_tbl [1:NUM_SLOTS];

  if (Y_ROW < 0 || Y_ROW >= (1 << COORD_W)) begin : g_yrow_err
    $error("Y_ROW does not fit in COORD_W bits");
  end
  if (SPEED < 1 || SPEED >= (1 << COORD_W)) begin : g_speed_err
    $error("SPEED out of range");
  end

  for (genvar i = 1; i <= NUM_SLOTS; i++) begin : g_slot
    if (slot_x_of(i) < 0 || slot_x_of(i) >= (1 << COORD_W)) begin : g_err
      $error("slot x does not fit in COORD_W bits");
    end
    assign slot_tbl[i] = COORD_W'(slot_x_of(i));
  end

  state_t             state;
  logic [COORD_W-1:0] tgt;
  logic               pos_ok;
  logic [COORD_W-1:0] req_x;

  // Decode the request; anything outside 1..NUM_SLOTS leaves pos_ok low.
  always_comb begin
    pos_ok = 1'b0;
    req_x  = '0;
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      if (pos == POS_W'(i)) begin
        pos_ok = 1'b1;
        req_x  = slot_tbl[i];
      end
    end
  end

  logic signed [COORD_W:0] diff;
  logic        [COORD_W:0] mag;
  logic        [COORD_W-1:0] step, nx;

  // One extra bit keeps the signed distance exact across the full coordinate range.
  always_comb begin
    diff = $signed({1'b0, tgt}) - $signed({1'b0, x});
    mag  = diff[COORD_W] ? $unsigned(-diff) : $unsigned(diff);
    step = (mag > SPD) ? SPD[COORD_W-1:0] : mag[COORD_W-1:0];
    nx   = diff[COORD_W] ? (x - step) : (x + step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HIDDEN;
      x       <= '0;
      y       <= '0;
      tgt     <= '0;
      busy    <= 1'b0;
      arrived <= 1'b0;
    end else begin
      arrived <= 1'b0;
      if (pos_valid) begin
        if (!pos_ok) begin
          state <= HIDDEN;
          x     <= '0;
          y     <= '0;
          tgt   <= '0;
          busy  <= 1'b0;
        end else if (state == HIDDEN) begin
          state   <= IDLE;
          x       <= req_x;
          y       <= YROW;
          tgt     <= req_x;
          busy    <= 1'b0;
          arrived <= 1'b1;
        end else begin
          tgt <= req_x;
          if (req_x == x) begin
            state   <= IDLE;
            busy    <= 1'b0;
            arrived <= 1'b1;
          end else begin
            state <= MOVING;
            busy  <= 1'b1;
          end
        end
      end else if (frame_tick && state == MOVING) begin
        x <= nx;
        if (nx == tgt) begin
          state   <= IDLE;
          busy    <= 1'b0;
          arrived <= 1'b1;
        end
      end
    end
  end

  assign visible_cond = visible && (state != HIDDEN);

endmodule

// File: tb/tb_sprite_pos_animator.sv
// Directed bench for sprite_pos_animator: default instance plus a SPEED=7 instance.
module tb_sprite_pos_animator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, pos_valid, visible;
  logic [7:0] pos;
  logic [9:0] x, y;
  logic       visible_cond, busy, arrived;

  logic       ft7, pv7;
  logic [7:0] pos7;
  logic [9:0] x7, y7;
  logic       vc7, busy7, arr7;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sprite_pos_animator dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pos(pos),
    .pos_valid(pos_valid), .visible(visible), .x(x), .y(y),
    .visible_cond(visible_cond), .busy(busy), .arrived(arrived)
  );

  sprite_pos_animator #(.SPEED(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .frame_tick(ft7), .pos(pos7),
    .pos_valid(pv7), .visible(visible), .x(x7), .y(y7),
    .visible_cond(vc7), .busy(busy7), .arrived(arr7)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; results are sampled on the next falling edge.
  task automatic req(input int p);
    pos_valid = 1'b1;
    pos = 8'(p);
    @(negedge clk);
    pos_valid = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 0; pos_valid = 0; pos = 0; visible = 1;
    ft7 = 0; pv7 = 0; pos7 = 0;
    #23;
    chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_vc", visible_cond, 0);
    chk("rst_busy", busy, 0); chk("rst_arr", arrived, 0);
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_x", x, 0); chk("post_rst_vc", visible_cond, 0);

    // SPEED=7 instance: jump to slot 1 (x=6), then glide to slot 2 (x=42)
    pv7 = 1; pos7 = 1; @(negedge clk); pos7 = 2; @(negedge clk); pv7 = 0;
    chk("s7_busy", busy7, 1); chk("s7_x0", x7, 6);
    for (int i = 1; i <= 6; i++) begin
      ft7 = 1; @(negedge clk); ft7 = 0;
      chk($sformatf("s7_x%0d", i), x7, (i < 6) ? 6 + 7 * i : 42);
      chk($sformatf("s7_arr%0d", i), arr7, (i == 6) ? 1 : 0);
    end
    chk("s7_busy_end", busy7, 0);

    // Jump from HIDDEN
    req(3);
    chk("jump_x", x, 82); chk("jump_y", y, 51); chk("jump_vc", visible_cond, 1);
    chk("jump_arr", arrived, 1); chk("jump_busy", busy, 0);
    @(negedge clk);
    chk("jump_arr_drop", arrived, 0);
    visible = 0; #1;
    chk("vc_masked", visible_cond, 0);
    visible = 1;

    // Same-slot request in IDLE arrives immediately
    req(3);
    chk("same_arr", arrived, 1); chk("same_busy", busy, 0);

    // 82 -> 122 in 10 ticks
    req(4);
    chk("mv_busy", busy, 1); chk("mv_x", x, 82); chk("mv_arr", arrived, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("mv_x%0d", i), x, 82 + 4 * i);
      chk($sformatf("mv_arr%0d", i), arrived, (i == 10) ? 1 : 0);
    end
    chk("mv_busy_end", busy, 0);
    tick(); tick(); tick();
    chk("idle_tick_x", x, 122); chk("idle_tick_arr", arrived, 0);

    // Retarget mid-move: toward slot 1 for 5 ticks, then to slot 5
    req(1);
    for (int i = 0; i < 5; i++) tick();
    chk("rt_x102", x, 102); chk("rt_busy", busy, 1);
    req(5);
    chk("rt_nojump", x, 102); chk("rt_busy2", busy, 1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 1) chk("rt_first", x, 106);
    end
    chk("rt_x162", x, 162); chk("rt_arr", arrived, 1);

    // Request and tick together: request wins, no step
    req(2);
    tick();
    chk("both_pre", x, 158);
    pos_valid = 1; pos = 3; frame_tick = 1;
    @(negedge clk);
    pos_valid = 0; frame_tick = 0;
    chk("both_nostep", x, 158); chk("both_busy", busy, 1);

    // Invalid code hides from MOVING
    req(7);
    chk("h7_x", x, 0); chk("h7_y", y, 0); chk("h7_vc", visible_cond, 0);
    chk("h7_busy", busy, 0); chk("h7_arr", arrived, 0);
    req(3); req(4); tick();
    chk("h0_pre", x, 86);
    req(0);
    chk("h0_x", x, 0); chk("h0_vc", visible_cond, 0); chk("h0_busy", busy, 0);

    // Asynchronous reset mid-move
    req(4); req(1);
    for (int i = 0; i < 5; i++) tick();
    chk("ar_pre", x, 102);
    #2 rst_n = 1'b0; #1;
    chk("ar_x", x, 0); chk("ar_y", y, 0); chk("ar_busy", busy, 0);
    chk("ar_vc", visible_cond, 0);
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    chk("ar_hold_x", x, 0); chk("ar_hold_vc", visible_cond, 0);
    chk("ar_hold_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_pos_animator.md
SPRITE_POS_ANIMATOR -- requirements
Module: sprite_pos_animator

Interface
REQ-001 Parameter NUM_SLOTS, default 6: number of valid slot codes (1..NUM_SLOTS); code 0 means hidden.
REQ-002 Parameter POS_W, default 8: width of pos.
REQ-003 Parameter COORD_W, default 10: width of x and y.
REQ-004 Parameters X0/X1/X_STEP, defaults 6/42/40: slot 1 x = X0; slot k>=2 x = X1 + (k-2)*X_STEP.
REQ-005 Parameter Y_ROW, default 51: y of every slot.
REQ-006 Parameter SPEED, default 4: max pixels moved per frame_tick; 1 <= SPEED < 2^COORD_W.
REQ-007 clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 frame_tick  input  1  one-cycle pulse per video frame (e.g. at vsync).
REQ-010 pos  input  POS_W  requested slot code.
REQ-011 pos_valid  input  1  pos sampled when high.
REQ-012 visible  input  1  external visibility enable.
REQ-013 x, y  output  COORD_W  registered current sprite position.
REQ-014 visible_cond  output  1  sprite drawn.
REQ-015 busy  output  1  high while in MOVING.
REQ-016 arrived  output  1  one-cycle pulse when sprite reaches its target.

Function
REQ-017 States: HIDDEN, IDLE, MOVING; state, x, y, target x, busy, arrived all registered.
REQ-018 Slot table computed at elaboration; every slot x and Y_ROW shall fit in COORD_W bits (elaboration error otherwise).
REQ-019 pos_valid with pos = 0 or pos > NUM_SLOTS: next cycle state HIDDEN, x = 0, y = 0, busy = 0, no arrived; applies from any state.
REQ-020 pos_valid with valid slot while HIDDEN: next cycle x = slot x, y = Y_ROW, state IDLE, arrived = 1 (jump, no animation).
REQ-021 pos_valid with valid slot while IDLE or MOVING: target latched; if target equals current x then state IDLE and arrived = 1 next cycle, else state MOVING next cycle.
REQ-022 Retarget during MOVING: motion continues from current x toward the new target; no jump.
REQ-023 frame_tick in MOVING (no pos_valid same cycle): x steps toward target by min(SPEED, |target - x|); direction by sign; no overshoot.
REQ-024 Step landing exactly on target: state IDLE and arrived = 1 on the same edge x is updated.
REQ-025 pos_valid and frame_tick in the same cycle: request applied, no step that cycle.
REQ-026 frame_tick in HIDDEN or IDLE: no effect.
REQ-027 y equals Y_ROW whenever state is not HIDDEN.
REQ-028 visible_cond = visible AND (state != HIDDEN), combinational.
REQ-029 arrived high for exactly one cycle per arrival; low otherwise.
REQ-030 Distance arithmetic uses COORD_W+1 bits signed; no wrap-around.

Reset
REQ-031 rst_n low, asynchronously: state HIDDEN, x = 0, y = 0, target = 0, busy = 0, arrived = 0, visible_cond = 0.
REQ-032 Reset asserted mid-MOVING discards target; after release sprite stays HIDDEN until a valid request.
REQ-033 Outputs hold reset values until first accepted pos_valid after rst_n release.

Verification (defaults unless stated)
REQ-034 Reset, visible = 1, pos_valid pos = 3 -> next cycle x = 82, y = 51, visible_cond = 1, arrived pulse, busy = 0.
REQ-035 From x = 82, pos = 4 -> busy = 1; after 10 frame_ticks x = 122, arrived pulse on 10th, busy = 0; frame_ticks without a request change nothing.
REQ-036 From x = 122, pos = 1; after 5 ticks x = 102; pos = 5 -> x increases, reaches 162 after 15 more ticks.
REQ-037 SPEED = 7, from x = 6 request pos = 2 -> x = 13,20,27,34,41,42 over 6 ticks; arrived on 6th.
REQ-038 pos_valid pos = 7 and pos = 0 in IDLE/MOVING -> HIDDEN, x = y = 0, visible_cond = 0; pos_valid and frame_tick together -> no step.
REQ-039 rst_n pulsed low mid-move (x = 102) -> outputs 0 immediately without clock; stays HIDDEN after release.
